// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction offer in, immediate result out.
// master = instruction producer / result consumer, slave = the pipeline.
interface imm_gen_pipe_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       inst;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] imm;
  logic              imm_hit;
  logic [2:0]        imm_kind;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, inst, in_tag, out_ready,
    input  in_ready, out_valid, imm, imm_hit, imm_kind, out_tag
  );

  modport slave (
    input  in_valid, inst, in_tag, out_ready,
    output in_ready, out_valid, imm, imm_hit, imm_kind, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator (decode, extend/shift); 2-cycle latency, one result/cycle, valid/ready stall.
// IMM_GEN_HOLD_EN: no-immediate opcodes repeat the last hit immediate instead of returning zero.
module imm_gen_pipe #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
) (
  input  logic         clk,
  input  logic         reset,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] K_NONE   = 3'd0;
  localparam logic [2:0] K_UPPER  = 3'd1;
  localparam logic [2:0] K_BRANCH = 3'd2;
  localparam logic [2:0] K_SHORT  = 3'd3;
  localparam logic [2:0] K_ZBYTE  = 3'd4;

  logic              r_s1_vld;
  logic [2:0]        r_s1_kind;
  logic [7:0]        r_s1_fld;
  logic [TAG_W-1:0]  r_s1_tag;

  logic              r_s2_vld;
  logic [DATA_W-1:0] r_s2_imm;
  logic              r_s2_hit;
  logic [2:0]        r_s2_kind;
  logic [TAG_W-1:0]  r_s2_tag;

  logic              w_out_xfer;
  logic              w_s2_load;
  logic              w_s1_mv;
  logic              w_s1_load;
  logic [2:0]        w_dec_kind;
  logic [7:0]        w_dec_fld;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_ext;
  logic [DATA_W-1:0] w_miss_imm;

  assign w_out_xfer   = r_s2_vld & bus.out_ready;
  assign w_s2_load    = ~r_s2_vld | w_out_xfer;
  assign w_s1_mv      = r_s1_vld & w_s2_load;
  assign w_s1_load    = ~r_s1_vld | w_s2_load;
  // Gated by reset so nothing is accepted while the pipeline is being flushed.
  assign bus.in_ready = reset & w_s1_load;

  // Short immediates are pre-sign-extended to 8 bits so S2 only ever extends a byte.
  always_comb begin
    w_dec_kind = K_NONE;
    w_dec_fld  = bus.inst[15:8];
    case (bus.inst[3:0])
      4'b0101: w_dec_kind = K_UPPER;
      4'b0110: w_dec_kind = K_BRANCH;
      4'b1000, 4'b1001, 4'b1010: begin
        w_dec_kind = K_SHORT;
        w_dec_fld  = {{4{bus.inst[7]}}, bus.inst[7:4]};
      end
      4'b1111: w_dec_kind = K_ZBYTE;
      default: w_dec_kind = K_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_kind <= K_NONE;
      r_s1_fld  <= 8'h00;
      r_s1_tag  <= '0;
    end else if (w_s1_load) begin
      r_s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_kind <= w_dec_kind;
        r_s1_fld  <= w_dec_fld;
        r_s1_tag  <= bus.in_tag;
      end
    end
  end

  assign w_sext = {{(DATA_W-8){r_s1_fld[7]}}, r_s1_fld};

  always_comb begin
    w_ext = w_miss_imm;
    case (r_s1_kind)
      K_UPPER:  w_ext = w_sext << 8;
      K_BRANCH: w_ext = w_sext << 1;
      K_SHORT:  w_ext = w_sext;
      K_ZBYTE:  w_ext = {{(DATA_W-8){1'b0}}, r_s1_fld};
      default:  w_ext = w_miss_imm;
    endcase
  end

`ifdef IMM_GEN_HOLD_EN
  logic [DATA_W-1:0] r_hold_imm;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_imm <= '0;
    end else if (w_s1_mv && (r_s1_kind != K_NONE)) begin
      r_hold_imm <= w_ext;
    end
  end

  assign w_miss_imm = r_hold_imm;
`else
  assign w_miss_imm = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_vld  <= 1'b0;
      r_s2_imm  <= '0;
      r_s2_hit  <= 1'b0;
      r_s2_kind <= K_NONE;
      r_s2_tag  <= '0;
    end else if (w_s2_load) begin
      r_s2_vld <= r_s1_vld;
      if (w_s1_mv) begin
        r_s2_imm  <= w_ext;
        r_s2_hit  <= (r_s1_kind != K_NONE);
        r_s2_kind <= r_s1_kind;
        r_s2_tag  <= r_s1_tag;
      end
    end
  end

  assign bus.out_valid = r_s2_vld;
  assign bus.imm       = r_s2_imm;
  assign bus.imm_hit   = r_s2_hit;
  assign bus.imm_kind  = r_s2_kind;
  assign bus.out_tag   = r_s2_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: 16- and 32-bit instances share stimulus; table vectors, corner sequences,
// then random traffic scored against an arithmetic reference model.
module tb_imm_gen_pipe;
  localparam int TAG_W = 4;
`ifdef IMM_GEN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [15:0]      inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_ready;

  imm_gen_pipe_if #(.DATA_W(16), .TAG_W(TAG_W)) b16 ();
  imm_gen_pipe_if #(.DATA_W(32), .TAG_W(TAG_W)) b32 ();

  assign b16.in_valid  = in_valid;
  assign b16.inst      = inst;
  assign b16.in_tag    = in_tag;
  assign b16.out_ready = out_ready;
  assign b32.in_valid  = in_valid;
  assign b32.inst      = inst;
  assign b32.in_tag    = in_tag;
  assign b32.out_ready = out_ready;

  imm_gen_pipe #(.DATA_W(16), .TAG_W(TAG_W)) dut16 (.clk(clk), .reset(reset), .bus(b16));
  imm_gen_pipe #(.DATA_W(32), .TAG_W(TAG_W)) dut32 (.clk(clk), .reset(reset), .bus(b32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [63:0]      imm;
    logic             hit;
    logic [2:0]       kind;
  } exp_t;

  exp_t        q16[$];
  exp_t        q32[$];
  logic [63:0] last16 = 64'd0;
  logic [63:0] last32 = 64'd0;

  function automatic exp_t model(input logic [15:0] ins, input logic [TAG_W-1:0] tg,
                                 input int w, input logic [63:0] last);
    exp_t   e;
    longint v;
    byte    hb;
    int     sh;
    hb = ins[15:8];
    sh = int'(ins[7:4]);
    if (sh > 7) sh = sh - 16;
    e.tag = tg;
    e.hit = 1'b1;
    case (ins[3:0])
      4'h5:             begin v = longint'(hb) * 256; e.kind = 3'd1; end
      4'h6:             begin v = longint'(hb) * 2;   e.kind = 3'd2; end
      4'h8, 4'h9, 4'hA: begin v = longint'(sh);       e.kind = 3'd3; end
      4'hF:             begin v = longint'(ins[15:8]); e.kind = 3'd4; end
      default: begin
        v      = HOLD ? longint'(last) : 64'sd0;
        e.hit  = 1'b0;
        e.kind = 3'd0;
      end
    endcase
    e.imm = 64'(v) & ((64'd1 << w) - 64'd1);
    return e;
  endfunction

  task automatic push16(input logic [15:0] ins, input logic [TAG_W-1:0] tg);
    exp_t e;
    e = model(ins, tg, 16, last16);
    if (e.hit) last16 = e.imm;
    q16.push_back(e);
  endtask

  task automatic push32(input logic [15:0] ins, input logic [TAG_W-1:0] tg);
    exp_t e;
    e = model(ins, tg, 32, last32);
    if (e.hit) last32 = e.imm;
    q32.push_back(e);
  endtask

  // Scoreboard: in-flight count predicts in_ready; results must pop in acceptance order.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      chk("rdy16", 64'(b16.in_ready), 64'((q16.size() < 2) || out_ready));
      chk("rdy32", 64'(b32.in_ready), 64'((q32.size() < 2) || out_ready));
      if (b16.out_valid && out_ready) begin
        if (q16.size() == 0) chk("sb16_extra", 64'(b16.out_valid), 64'd0);
        else begin
          e = q16.pop_front();
          chk("sb16_tag",  64'(b16.out_tag),  64'(e.tag));
          chk("sb16_imm",  64'(b16.imm),      e.imm);
          chk("sb16_hit",  64'(b16.imm_hit),  64'(e.hit));
          chk("sb16_kind", 64'(b16.imm_kind), 64'(e.kind));
        end
      end
      if (b32.out_valid && out_ready) begin
        if (q32.size() == 0) chk("sb32_extra", 64'(b32.out_valid), 64'd0);
        else begin
          e = q32.pop_front();
          chk("sb32_tag",  64'(b32.out_tag),  64'(e.tag));
          chk("sb32_imm",  64'(b32.imm),      e.imm);
          chk("sb32_hit",  64'(b32.imm_hit),  64'(e.hit));
          chk("sb32_kind", 64'(b32.imm_kind), 64'(e.kind));
        end
      end
      if (in_valid && b16.in_ready) push16(inst, in_tag);
      if (in_valid && b32.in_ready) push32(inst, in_tag);
    end
  end

  typedef struct {
    logic [15:0] inst;
    logic [15:0] e16;
    logic [31:0] e32;
    logic        hit;
    logic [2:0]  kind;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          next;
    int          got[$];
    logic [31:0] r;

    tbl[0]  = '{16'h8005, 16'h8000, 32'hFFFF8000, 1'b1, 3'd1};
    tbl[1]  = '{16'h0306, 16'h0006, 32'h00000006, 1'b1, 3'd2};
    tbl[2]  = '{16'h1234, HOLD ? 16'h0006 : 16'h0000, HOLD ? 32'h00000006 : 32'h0, 1'b0, 3'd0};
    tbl[3]  = '{16'h00F8, 16'hFFFF, 32'hFFFFFFFF, 1'b1, 3'd3};
    tbl[4]  = '{16'hFF0F, 16'h00FF, 32'h000000FF, 1'b1, 3'd4};
    tbl[5]  = '{16'h7F95, 16'h7F00, 32'h00007F00, 1'b1, 3'd1};
    tbl[6]  = '{16'h8096, 16'hFF00, 32'hFFFFFF00, 1'b1, 3'd2};
    tbl[7]  = '{16'h0079, 16'h0007, 32'h00000007, 1'b1, 3'd3};
    tbl[8]  = '{16'h008A, 16'hFFF8, 32'hFFFFFFF8, 1'b1, 3'd3};
    tbl[9]  = '{16'hABC7, HOLD ? 16'hFFF8 : 16'h0000, HOLD ? 32'hFFFFFFF8 : 32'h0, 1'b0, 3'd0};
    tbl[10] = '{16'hFFF6, 16'hFFFE, 32'hFFFFFFFE, 1'b1, 3'd2};
    tbl[11] = '{16'h0000, HOLD ? 16'hFFFE : 16'h0000, HOLD ? 32'hFFFFFFFE : 32'h0, 1'b0, 3'd0};

    in_valid = 1'b0; inst = 16'h0; in_tag = '0; out_ready = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(b16.out_valid), 64'd0);
    chk("rst_in_ready",  64'(b16.in_ready),  64'd0);
    chk("rst_imm",       64'(b16.imm),       64'd0);
    chk("rst_hit_kind",  64'({b16.imm_hit, b16.imm_kind}), 64'd0);
    chk("rst_tag",       64'(b16.out_tag),   64'd0);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(b16.in_ready), 64'd1);

    // One instruction at a time: exact 2-cycle latency and decoded fields.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; inst = tbl[i].inst; in_tag = TAG_W'(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("tbl_early_valid", 64'(b16.out_valid), 64'd0);
      @(posedge clk); #1;
      chk("tbl_valid",  64'(b16.out_valid), 64'd1);
      chk("tbl_imm16",  64'(b16.imm),       64'(tbl[i].e16));
      chk("tbl_imm32",  64'(b32.imm),       64'(tbl[i].e32));
      chk("tbl_hit",    64'(b16.imm_hit),   64'(tbl[i].hit));
      chk("tbl_kind",   64'(b16.imm_kind),  64'(tbl[i].kind));
      chk("tbl_kind32", 64'(b32.imm_kind),  64'(tbl[i].kind));
      chk("tbl_tag",    64'(b16.out_tag),   64'(i[TAG_W-1:0]));
    end

    // Back-to-back pair on the 32-bit instance.
    @(posedge clk); #1;
    in_valid = 1'b1; inst = 16'h8005; in_tag = 4'd1;
    @(posedge clk); #1;
    inst = 16'h0306; in_tag = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_first_imm32",  64'(b32.imm),     64'hFFFF8000);
    chk("b2b_first_tag",    64'(b32.out_tag), 64'd1);
    @(posedge clk); #1;
    chk("b2b_second_valid", 64'(b32.out_valid), 64'd1);
    chk("b2b_second_imm32", 64'(b32.imm),       64'h00000006);
    chk("b2b_second_tag",   64'(b32.out_tag),   64'd2);

    // Stall for 5 cycles offering tags 1..3, then release.
    @(posedge clk);
    next = 1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      out_ready = (c >= 5);
      in_valid  = (next <= 3);
      in_tag    = TAG_W'(next);
      inst      = {8'(next), 8'h06};
      #3;
      if (c == 4) begin
        chk("stall_accepts",  64'(next - 1),    64'd2);
        chk("stall_in_ready", 64'(b16.in_ready), 64'd0);
      end
      if (c >= 2 && c <= 4) begin
        chk("stall_valid", 64'(b16.out_valid), 64'd1);
        chk("stall_imm",   64'(b16.imm),       64'h0002);
        chk("stall_kind",  64'(b16.imm_kind),  64'd2);
        chk("stall_tag",   64'(b16.out_tag),   64'd1);
      end
      if (in_valid && b16.in_ready) next++;
      if (b16.out_valid && out_ready) got.push_back(int'(b16.out_tag));
    end
    chk("stall_delivered", 64'(got.size()), 64'd3);
    for (int k = 0; k < got.size() && k < 3; k++) chk("stall_order", 64'(got[k]), 64'(k + 1));

    // Async reset with both stages full.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; inst = 16'h8005; in_tag = 4'd5;
    @(posedge clk); #1;
    inst = 16'h0306; in_tag = 4'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_stall_ready", 64'(b16.in_ready),  64'd0);
    chk("full_out_valid",   64'(b16.out_valid), 64'd1);
    #2;
    reset = 1'b0;
    q16.delete(); q32.delete();
    last16 = 64'd0; last32 = 64'd0;
    #1;
    chk("arst_out_valid16", 64'(b16.out_valid), 64'd0);
    chk("arst_out_valid32", 64'(b32.out_valid), 64'd0);
    chk("arst_in_ready",    64'(b16.in_ready),  64'd0);
    chk("arst_imm",         64'(b16.imm),       64'd0);
    chk("arst_hit_kind",    64'({b16.imm_hit, b16.imm_kind}), 64'd0);
    chk("arst_tag",         64'(b16.out_tag),   64'd0);
    @(posedge clk); #1;
    chk("arst_hold_ready",  64'(b16.in_ready),  64'd0);
    @(posedge clk); #2;
    reset = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 64'(b16.in_ready), 64'd1);
    in_valid = 1'b1; inst = 16'h00F8; in_tag = 4'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rel_early_valid", 64'(b16.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("rel_valid", 64'(b16.out_valid), 64'd1);
    chk("rel_imm",   64'(b16.imm),       64'hFFFF);
    chk("rel_tag",   64'(b16.out_tag),   64'd7);

    // Random traffic with random backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      r         = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      inst      = r[15:0];
      in_tag    = r[19:16];
      out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && (q16.size() != 0 || q32.size() != 0); c++) @(posedge clk);
    #1;
    chk("drain16", 64'(q16.size()), 64'd0);
    chk("drain32", 64'(q32.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter DATA_W, default 16, immediate output width; legal values are 16 or more.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag that travels with each instruction.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  an instruction is offered on inst and in_tag.
REQ-006 in_ready  output  1  the block accepts the offered instruction this cycle.
REQ-007 inst  input  16  instruction word; the opcode is inst[3:0].
REQ-008 in_tag  input  TAG_W  opaque tag; it is returned unchanged with the result.
REQ-009 out_valid  output  1  a result is presented.
REQ-010 out_ready  input  1  the consumer takes the result this cycle.
REQ-011 imm  output  DATA_W  generated immediate.
REQ-012 imm_hit  output  1  the opcode carries an immediate.
REQ-013 imm_kind  output  3  immediate class: 0 none, 1 upper, 2 branch, 3 short, 4 zero-extended byte.
REQ-014 out_tag  output  TAG_W  tag of the presented result.

Function
REQ-015 Transfers: an input transfer occurs when in_valid and in_ready are both high; an output transfer occurs when out_valid and out_ready are both high.
REQ-016 Pipeline: two stages, S1 (decode) and S2 (extend/shift). Each stage holds a valid bit plus its payload.
REQ-017 Latency: an accepted instruction appears on the outputs exactly 2 cycles after acceptance, provided out_ready stayed high.
REQ-018 Throughput: with out_ready held high, one result per cycle.
REQ-019 S2 load rule: S2 loads from S1 when S2 is empty or an output transfer occurs this cycle.
REQ-020 S1 load rule: S1 loads from the input when S1 is empty or S1 moves to S2 this cycle.
REQ-021 in_ready equals that S1 load condition and is purely combinational from stage state and out_ready; it does not depend on in_valid.
REQ-022 Decoding by opcode:
  - 0101: upper immediate, sext(inst[15:8]) << 8.
  - 0110: branch immediate, sext(inst[15:8]) << 1.
  - 1000, 1001, 1010: short immediate, sext(inst[7:4]).
  - 1111: zero-extended byte, zext(inst[15:8]).
REQ-023 Width rule: sign or zero extension is to DATA_W bits before any shift; shift results are truncated to DATA_W bits.
REQ-024 Any other opcode produces imm_hit=0 and imm_kind=0; the imm value for this case is set by REQ-032.
REQ-025 Output stability: while out_valid=1 and out_ready=0, imm, imm_hit, imm_kind and out_tag hold stable, and no accepted instruction is lost or duplicated.
REQ-026 Full stall: with both stages full and out_ready=0, in_ready=0.
REQ-027 Simultaneous accept and drain: when both stages are full and out_ready=1, in_ready=1 and all three transfers (input to S1, S1 to S2, S2 out) happen in the same cycle.
REQ-028 Ordering: results leave in strict acceptance order.

Reset
REQ-029 Asserting reset clears both stage valid bits immediately, without waiting for a clock edge. It also forces out_valid=0, imm=0, imm_hit=0, imm_kind=0 and out_tag=0.
REQ-030 While reset is low, in_ready=0. Instructions in flight when reset asserts are discarded.
REQ-031 After reset deasserts, in_ready=1 from the first rising edge onward.

Configuration
REQ-032 Macro IMM_GEN_HOLD_EN selects the imm value for no-immediate opcodes:
  - Defined: imm repeats the imm of the most recent result that had imm_hit=1, or 0 if there has been none since reset. This value is held in a register updated at S2 load.
  - Undefined: imm=0 for no-immediate opcodes.
  - imm_hit and imm_kind are identical in both builds.

Verification
REQ-033 DATA_W=16, out_ready=1, accept inst 0x8005 -> 2 cycles later imm=0x8000, imm_kind=1, imm_hit=1.
REQ-034 DATA_W=32, accept inst 0x8005 then 0x0306 back to back -> imm=0xFFFF8000, then imm=0x00000006 on the next cycle, in order.
REQ-035 DATA_W=16, accept 0x00F8 then 0xFF0F -> imm=0xFFFF (kind 3), then imm=0x00FF (kind 4).
REQ-036 Accept 0x0306 then 0x1234 -> second result has imm_hit=0 and imm_kind=0; imm=0x0006 with IMM_GEN_HOLD_EN defined, imm=0x0000 without it.
REQ-037 Hold out_ready=0 for 5 cycles with tags 1, 2, 3 offered -> in_ready falls after 2 accepts and outputs stay stable; on release, tags 1, 2, 3 are delivered in order with no loss.
REQ-038 Assert reset while both stages are full -> out_valid=0 and in_ready=0 immediately, with no clock edge; after release the first accepted instruction appears 2 cycles later.
